rv32i_alu: RTL and testbench
============================

# rv32i_alu

Integer arithmetic/logic unit for the RV32I multi-cycle core. It executes OP and OP-IMM operations from funct3/funct7, with the second operand supplied as either a register value or the sign-extended I-immediate. The result is registered once per clock. The core latches its operands in DECODE and reads `out` at WRITEBACK, so one-cycle latency is hidden by the EXEC state.

## Interface
- No parameters.
- `clk` input 1: system clock, rising-edge active.
- `rst` input 1: asynchronous, active-low reset.
- `in1` input 32: operand A (rs1 value).
- `in2` input 32: operand B (rs2 value, or sign-extended imm_i when `is_imm`=1).
- `is_imm` input 1: 1 = OP-IMM encoding, 0 = OP (register-register) encoding.
- `funct3` input 3: operation select, instruction[14:12].
- `funct7` input 7: instruction[31:25]; for immediates this is imm[11:5].
- `out` output 32: registered result.

## Operation
Result by funct3 (all arithmetic modulo 2^32):
- 000: ADD. SUB (in1−in2) only when `is_imm`=0 and funct7[5]=1. ADDI ignores funct7.
- 001: SLL, in1 << in2[4:0].
- 010: SLT, signed in1<in2 → 32'd1, else 0.
- 011: SLTU, unsigned compare, same encoding.
- 100: XOR.
- 101: SRL (funct7[5]=0) or SRA (funct7[5]=1, sign-fill). Applies to both register and immediate forms; shamt = in2[4:0].
- 110: OR.
- 111: AND.
- Shift amounts use in2[4:0] only. Upper bits of in2 and all other funct7 bits are ignored, except as described under Configuration.
- SLT/SLTU immediate forms compare against the already-sign-extended in2.
- There are no illegal encodings. Any funct7 pattern not listed decodes as the base operation above.

## Timing
- Combinational result is captured into `out` on every rising `clk`, so latency is 1 cycle. No enable and no handshake.
- `out` is 0 while `rst`=0. Reset asserts asynchronously and deasserts on any edge. The first capture occurs on the first rising `clk` with `rst`=1.
- The core must hold in1/in2/funct3/funct7/is_imm stable for at least one full cycle before reading `out`. DECODE→EXEC→WRITEBACK guarantees this.
- Reset asserted mid-operation clears `out` immediately. The next valid result appears one edge after release.
- Input changes between edges have no effect on `out` until the next edge.

## Configuration
- `ALU_MUL_EN` defined: when `is_imm`=0 and funct7=7'b0000001, funct3 selects an RV32M multiply operation:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32 bits, signed×signed.
  - 010 MULHSU: high 32 bits, signed×unsigned.
  - 011 MULHU: high 32 bits, unsigned×unsigned.
  - 1xx (divide/remainder): result is 0.
- Multiply uses the same single-cycle registered latency.
- `ALU_MUL_EN` undefined: funct7=0000001 decodes as the base RV32I operation for that funct3 (funct7[5]=0).

## Test plan
- Reset: assert `rst`=0 with `out` holding 0x1234 → `out`=0 immediately. Release; in1=5, in2=7, ADD → `out`=12 after one edge.
- Add/sub: in1=3, in2=5.
  - OP, funct7=0x20 → 0xFFFFFFFE.
  - Same operands with `is_imm`=1 → 8 (no SUBI).
- Shifts: in1=0x80000000, in2=0x24.
  - SRL → 0x08000000 (shamt 4).
  - SRA (funct7=0x20) → 0xF8000000.
  - SLL of in1=1 → 0x10.
- Compares: in1=0xFFFFFFFF, in2=1 → SLT=1, SLTU=0. Equal operands → both 0.
- Logic: in1=0xF0F0F0F0, in2=0x0FF00FF0 → XOR=0xFF00FF00, OR=0xFFF0FFF0, AND=0x00F000F0.
- With `ALU_MUL_EN`: in1=0xFFFFFFFF, in2=2, funct7=1.
  - MUL=0xFFFFFFFE.
  - MULH=0xFFFFFFFF.
  - MULHU=1.
  - DIV encodings → 0.

Source files
------------

// File: rtl/rv32i_alu.sv
// RV32I integer ALU with a registered result (one-cycle latency).
// Define ALU_MUL_EN to add the RV32M multiply group; divide encodings then return 0.
module rv32i_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        is_imm,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] out
);

    logic [4:0]  shamt;
    logic        is_mext;
    logic        alt;
    logic [31:0] base_res;
    logic [31:0] res;

    assign shamt   = in2[4:0];
    assign is_mext = !is_imm && (funct7 == 7'b0000001);
    // funct7==0000001 already has bit 5 clear, so folding is_mext in changes nothing for the base ops
    assign alt     = funct7[5] && !is_mext;

    always_comb begin
        base_res = 32'd0;
        case (funct3)
            3'b000: base_res = (!is_imm && alt) ? (in1 - in2) : (in1 + in2);
            3'b001: base_res = in1 << shamt;
            3'b010: base_res = ($signed(in1) < $signed(in2)) ? 32'd1 : 32'd0;
            3'b011: base_res = (in1 < in2) ? 32'd1 : 32'd0;
            3'b100: base_res = in1 ^ in2;
            3'b101: base_res = alt ? 32'($signed(in1) >>> shamt) : (in1 >> shamt);
            3'b110: base_res = in1 | in2;
            3'b111: base_res = in1 & in2;
            default: base_res = 32'd0;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [63:0] ext1_s;
    logic [63:0] ext2_s;
    logic [63:0] ext1_u;
    logic [63:0] ext2_u;
    logic [63:0] prod_ss;
    logic [63:0] prod_su;
    logic [63:0] prod_uu;
    logic [31:0] mul_res;

    // Signed products are formed modulo 2^64 on sign-extended operands.
    assign ext1_s  = {{32{in1[31]}}, in1};
    assign ext2_s  = {{32{in2[31]}}, in2};
    assign ext1_u  = {32'd0, in1};
    assign ext2_u  = {32'd0, in2};
    assign prod_ss = ext1_s * ext2_s;
    assign prod_su = ext1_s * ext2_u;
    assign prod_uu = ext1_u * ext2_u;

    always_comb begin
        mul_res = 32'd0;
        case (funct3)
            3'b000: mul_res = prod_uu[31:0];
            3'b001: mul_res = prod_ss[63:32];
            3'b010: mul_res = prod_su[63:32];
            3'b011: mul_res = prod_uu[63:32];
            default: mul_res = 32'd0;
        endcase
    end

    assign res = is_mext ? mul_res : base_res;
`else
    assign res = base_res;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= 32'd0;
        end else begin
            out <= res;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for rv32i_alu; expectations are hand-computed constants.
// Build with ALU_MUL_EN defined to also exercise the multiply group.
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        is_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] out;

    int n_checks;
    int n_pass;

    rv32i_alu dut (
        .clk    (clk),
        .rst    (rst),
        .in1    (in1),
        .in2    (in2),
        .is_imm (is_imm),
        .funct3 (funct3),
        .funct7 (funct7),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic imm,
                         input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        in1    = a;
        in2    = b;
        is_imm = imm;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic imm, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] exp);
        drive(a, b, imm, f3, f7);
        @(posedge clk);
        #1;
        check_val(tag, out, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst    = 1'b0;
        in1    = 32'd0;
        in2    = 32'd0;
        is_imm = 1'b0;
        funct3 = 3'b000;
        funct7 = 7'd0;

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_out", out, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        run("load_1234", 32'h0000_1234, 32'd0, 1'b0, 3'b000, 7'h00, 32'h0000_1234);

        // async assertion mid-cycle, with new operands pending
        in1 = 32'd5;
        in2 = 32'd7;
        #2;
        rst = 1'b0;
        #1;
        check_val("async_clear", out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("hold_after_release", out, 32'd0);
        @(posedge clk);
        #1;
        check_val("first_after_release", out, 32'd12);

        // inputs changed between edges must not reach out
        @(negedge clk);
        in1 = 32'd100;
        #2;
        check_val("no_comb_path", out, 32'd12);

        run("sub",        32'd3, 32'd5, 1'b0, 3'b000, 7'h20, 32'hFFFF_FFFE);
        run("addi_no_sub", 32'd3, 32'd5, 1'b1, 3'b000, 7'h20, 32'd8);
        run("add",        32'd3, 32'd5, 1'b0, 3'b000, 7'h00, 32'd8);

        run("srl",  32'h8000_0000, 32'h24, 1'b0, 3'b101, 7'h00, 32'h0800_0000);
        run("sra",  32'h8000_0000, 32'h24, 1'b0, 3'b101, 7'h20, 32'hF800_0000);
        run("srai", 32'h8000_0000, 32'h24, 1'b1, 3'b101, 7'h20, 32'hF800_0000);
        run("sll",  32'h0000_0001, 32'h24, 1'b0, 3'b001, 7'h00, 32'h0000_0010);
        run("sll_max", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 3'b001, 7'h00, 32'h8000_0000);

        run("slt_neg",  32'hFFFF_FFFF, 32'd1, 1'b0, 3'b010, 7'h00, 32'd1);
        run("sltu_neg", 32'hFFFF_FFFF, 32'd1, 1'b0, 3'b011, 7'h00, 32'd0);
        run("slt_eq",   32'd9, 32'd9, 1'b0, 3'b010, 7'h00, 32'd0);
        run("sltu_eq",  32'd9, 32'd9, 1'b0, 3'b011, 7'h00, 32'd0);
        run("slti_imm", 32'd1, 32'hFFFF_FFFF, 1'b1, 3'b010, 7'h7F, 32'd0);
        run("sltiu_imm", 32'd1, 32'hFFFF_FFFF, 1'b1, 3'b011, 7'h7F, 32'd1);

        run("xor", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b100, 7'h00, 32'hFF00_FF00);
        run("or",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b110, 7'h00, 32'hFFF0_FFF0);
        run("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b111, 7'h00, 32'h00F0_00F0);

        // funct7=1 with an immediate is always the base op
        run("addi_f7_1", 32'hFFFF_FFFF, 32'd2, 1'b1, 3'b000, 7'h01, 32'd1);
`ifdef ALU_MUL_EN
        run("mul",    32'hFFFF_FFFF, 32'd2, 1'b0, 3'b000, 7'h01, 32'hFFFF_FFFE);
        run("mulh",   32'hFFFF_FFFF, 32'd2, 1'b0, 3'b001, 7'h01, 32'hFFFF_FFFF);
        run("mulhsu", 32'hFFFF_FFFF, 32'd2, 1'b0, 3'b010, 7'h01, 32'hFFFF_FFFF);
        run("mulhu",  32'hFFFF_FFFF, 32'd2, 1'b0, 3'b011, 7'h01, 32'd1);
        run("mulhsu_b", 32'd2, 32'hFFFF_FFFF, 1'b0, 3'b010, 7'h01, 32'd1);
        run("div",    32'hFFFF_FFFF, 32'd2, 1'b0, 3'b100, 7'h01, 32'd0);
        run("divu",   32'hFFFF_FFFF, 32'd2, 1'b0, 3'b101, 7'h01, 32'd0);
        run("rem",    32'hFFFF_FFFF, 32'd2, 1'b0, 3'b110, 7'h01, 32'd0);
        run("remu",   32'hFFFF_FFFF, 32'd2, 1'b0, 3'b111, 7'h01, 32'd0);
`else
        run("f7_1_add",  32'hFFFF_FFFF, 32'd2, 1'b0, 3'b000, 7'h01, 32'd1);
        run("f7_1_sll",  32'hFFFF_FFFF, 32'd2, 1'b0, 3'b001, 7'h01, 32'hFFFF_FFFC);
        run("f7_1_slt",  32'hFFFF_FFFF, 32'd2, 1'b0, 3'b010, 7'h01, 32'd1);
        run("f7_1_xor",  32'hFFFF_FFFF, 32'd2, 1'b0, 3'b100, 7'h01, 32'hFFFF_FFFD);
        run("f7_1_srl",  32'h8000_0000, 32'd2, 1'b0, 3'b101, 7'h01, 32'h2000_0000);
        run("f7_1_and",  32'hFFFF_FFFF, 32'd2, 1'b0, 3'b111, 7'h01, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
